display7_scan: RTL



---
 rtl/display7_scan.sv | 113 +++++++++++
 1 files changed

// File: rtl/display7_scan.sv
// Time-multiplexed driver for a bank of common-anode seven-segment digits.
// Latches a packed nibble word on iLoad and scans one digit per CLK_DIV cycles.
module display7_scan #(
    parameter int unsigned DIGITS    = 8,
    parameter int unsigned CLK_DIV   = 100000,
    parameter int unsigned BLANK_CYC = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iLoad,
    input  logic [4*DIGITS-1:0]   iData,
    input  logic [DIGITS-1:0]     iDp,
    input  logic [DIGITS-1:0]     iBlank,
    input  logic                  iHex,
    input  logic                  iLzs,
    output logic [6:0]            oSeg,
    output logic                  oDp,
    output logic [DIGITS-1:0]     oAn
);

    localparam int unsigned DATA_W = 4 * DIGITS;
    localparam int unsigned CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [6:0]  SEG_OFF = 7'h7F;

    logic [DATA_W-1:0] shData;
    logic [DIGITS-1:0] shDp;
    logic [DIGITS-1:0] shBlank;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx;

    logic [DIGITS-1:0] suppress;
    logic [3:0]        nibble;
    logic [6:0]        segNext;
    logic              dpNext;
    logic [DIGITS-1:0] anNext;

    // Active-low gfedcba glyphs; 10..15 are dark unless hex mode is on.
    function automatic logic [6:0] glyphOf(input logic [3:0] v, input logic hex);
        case (v)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return hex ? 7'b0001000 : SEG_OFF;
            4'hB: return hex ? 7'b0000011 : SEG_OFF;
            4'hC: return hex ? 7'b1000110 : SEG_OFF;
            4'hD: return hex ? 7'b0100001 : SEG_OFF;
            4'hE: return hex ? 7'b0000110 : SEG_OFF;
            default: return hex ? 7'b0001110 : SEG_OFF;
        endcase
    endfunction

    // A digit is a leading zero when it and every more significant nibble is zero.
    always_comb begin
        logic allZero;
        suppress = '0;
        allZero  = 1'b1;
        for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
            allZero     = allZero & (shData[4*k +: 4] == 4'h0);
            suppress[k] = iLzs & (k > 0) & allZero;
        end
    end

    always_comb begin
        segNext = SEG_OFF;
        dpNext  = 1'b1;
        anNext  = '1;
        nibble  = shData[4*int'(idx) +: 4];
        if (32'(cnt) >= BLANK_CYC) begin
            anNext = ~(DIGITS'(1) << idx);
            if (!shBlank[idx]) begin
                segNext = suppress[idx] ? SEG_OFF : glyphOf(nibble, iHex);
                dpNext  = ~shDp[idx];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shData  <= '0;
            shDp    <= '0;
            shBlank <= '0;
            cnt     <= '0;
            idx     <= '0;
            oSeg    <= SEG_OFF;
            oDp     <= 1'b1;
            oAn     <= '1;
        end else begin
            if (iLoad) begin
                shData  <= iData;
                shDp    <= iDp;
                shBlank <= iBlank;
            end
            if (cnt == CNT_W'(CLK_DIV - 1)) begin
                cnt <= '0;
                idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            oSeg <= segNext;
            oDp  <= dpNext;
            oAn  <= anNext;
        end
    end

endmodule
